irq_sched: RTL and testbench
============================

Name: irq_sched

Overview:
- Interrupt scheduler for the single-cycle MIPS core.
- Edge-detects external interrupt sources (timer, UART RX/TX, button) and latches them as pending.
- Masks pending sources through a bus-writable enable register and selects the highest-priority one.
- Sequences one request at a time into Control's IRQ input, holding off further requests until the handler returns; sits on the peripheral bus beside Peripheral.

Parameters:
- NSRC, 4, number of interrupt sources (1..4); source 0 has highest priority.
- BASE, 32'h4000_0030, byte address of the register block (3 words).

Ports:
- clk  input  1  CPU clock (myclk domain); all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state.
- src  input  NSRC  interrupt request levels; a rising edge makes a request.
- monin  input  1  PC[31], high while the CPU is in kernel/handler mode.
- eret  input  1  one-cycle pulse, high when the CPU executes the handler return (jr $26).
- rd  input  1  bus read strobe.
- wr  input  1  bus write strobe.
- addr  input  32  bus byte address.
- wdata  input  32  bus write data.
- rdata  output  32  bus read data.
- irq_req  output  1  interrupt request to Control.
- irq_id  output  2  index of the requested or in-service source.

Behaviour:
- Reset (reset=0, async): src_d=0, pending=0, enable=0, state=IDLE, svc_id=0; irq_req=0, irq_id=0, rdata=0.
- Edge detect: src_d <= src each clock; edge = src & ~src_d.
- Pending update: pending[i] <= (pending[i] & ~clr[i]) | edge[i]. If set and clear hit the same bit in the same cycle, set wins.
- clr sources: the W1C write to PENDING, or the bit selected on the REQ->SVC transition.
- Candidate: act = pending & enable. sel = lowest set index of act.
- State machine (states IDLE, REQ, SVC):
  - IDLE: if act!=0 and monin=0, go to REQ and latch svc_id=sel. Otherwise stay.
  - REQ: irq_req=1 and irq_id=svc_id.
    - If act[svc_id] becomes 0 (disabled or cleared by software), go to IDLE with irq_req dropped. Re-arbitration then takes one cycle.
    - If a higher-priority source arrives while in REQ, svc_id is not updated.
    - If monin=1 (CPU has entered the handler), go to SVC and clear pending[svc_id].
  - SVC: irq_req=0 and irq_id=svc_id. New edges still set pending but no request is made. On eret=1, go to IDLE.
  - eret outside SVC is ignored.
- Latency: src rises before edge k, so pending=1 after edge k. irq_req=1 after edge k+1 when enabled and monin=0. irq_req is decoded from the state register only (glitch-free).
- Back-to-back requests: after eret, the next request is asserted one cycle later if act!=0.
- Register map (word offsets from BASE; a decode hit requires addr[31:4]==BASE[31:4] and addr[3:2] in 0..2):
  - 0x0 ENABLE: R/W, bits[NSRC-1:0]; upper bits read 0.
  - 0x4 PENDING: R; write-1-to-clear.
  - 0x8 STATUS: RO = {26'b0, state[1:0], 2'b0, svc_id[1:0]}, with IDLE=0, REQ=1, SVC=2.
- Writes take effect at the clock edge where wr=1 and the address hits.
- An ENABLE write that clears enable[svc_id] during REQ drops irq_req on the following cycle.
- rdata: combinational, the selected register when rd=1 and the address hits; otherwise 0.
- Misaligned addresses (addr[1:0]!=0) and offset 0xC decode as a miss.
- Reset asserted mid-REQ or mid-SVC: immediate return to IDLE, irq_req=0, all registers cleared.

Test Plan:
- Reset, write ENABLE=4'b0010, pulse src[1] with monin=0 -> irq_req=1, irq_id=1 two clocks after the rise. Drive monin=1 -> STATUS=32'h0000_0021, PENDING=0, irq_req=0.
- Raise src[2] and src[0] in the same cycle with ENABLE=4'hF -> irq_id=0. After eret with monin=0 -> irq_req=1, irq_id=2 one cycle later.
- In REQ for id 3, write ENABLE=4'b0111 -> irq_req=0 next cycle, STATUS=32'h0000_0003 (IDLE, svc_id 3), PENDING=4'b1000.
- Edge on src[1] in the same cycle as a W1C write to PENDING bit 1 -> PENDING reads 4'b0010.
- During SVC, pulse src[0] -> no irq_req until eret. Then irq_req=1 with irq_id=0.
- Assert reset (0) during REQ -> irq_req=0 and ENABLE, PENDING, STATUS read 0 immediately, without waiting for a clock. A read at BASE+0xC returns 0.

Source files
------------

// File: rtl/irq_sched_if.sv
// irq_sched_if: peripheral bus bundle between the CPU bus master and irq_sched.
interface irq_sched_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master (output rd, wr, addr, wdata, input rdata);
   modport slave (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/irq_sched.sv
// irq_sched: edge-detected, maskable, fixed-priority interrupt sequencer feeding one request at a time to Control.
module irq_sched #(
   parameter int          NSRC = 4,
   parameter logic [31:0] BASE = 32'h4000_0030
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic            monin,
   input  logic            eret,
   irq_sched_if.slave      bus,
   output logic            irq_req,
   output logic [1:0]      irq_id
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2} state_t;
   state_t          state_q, state_d;
   logic [NSRC-1:0] src_q, pending_q, pending_d, enable_q, enable_d, act, edge_v;
   logic [3:0]      act_w, clr_w;
   logic [1:0]      svc_id_q, svc_id_d, sel, off;
   logic            hit;
   assign hit    = bus.addr[31:4] == BASE[31:4] && bus.addr[3:2] != 2'd3 && bus.addr[1:0] == 2'b00;
   assign off    = bus.addr[3:2];
   assign edge_v = src & ~src_q;
   assign act    = pending_q & enable_q;
   assign act_w  = 4'(act);
   assign irq_req = state_q == REQ;
   assign irq_id  = svc_id_q;
   always_comb begin
      sel = 2'd0;
      for (int i = NSRC - 1; i >= 0; i--) if (act[i]) sel = 2'(i);
   end
   // A request that loses its enable or pending bit is withdrawn before the CPU can take it.
   always_comb begin
      state_d  = state_q;
      svc_id_d = svc_id_q;
      clr_w    = bus.wr && hit && off == 2'd1 ? 4'(bus.wdata[NSRC-1:0]) : 4'd0;
      case (state_q)
         IDLE: if (|act && !monin) begin
            state_d  = REQ;
            svc_id_d = sel;
         end
         REQ: if (!act_w[svc_id_q]) state_d = IDLE;
            else if (monin) begin
               state_d         = SVC;
               clr_w[svc_id_q] = 1'b1;
            end
         SVC: if (eret) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      pending_d = (pending_q & ~clr_w[NSRC-1:0]) | edge_v;
      enable_d  = bus.wr && hit && off == 2'd0 ? bus.wdata[NSRC-1:0] : enable_q;
   end
   always_comb
      bus.rdata = !(bus.rd && hit) ? 32'd0 :
                  off == 2'd0 ? 32'(enable_q) :
                  off == 2'd1 ? 32'(pending_q) : {26'd0, state_q, 2'd0, svc_id_q};
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q   <= IDLE;
         svc_id_q  <= 2'd0;
         src_q     <= '0;
         pending_q <= '0;
         enable_q  <= '0;
      end else begin
         state_q   <= state_d;
         svc_id_q  <= svc_id_d;
         src_q     <= src;
         pending_q <= pending_d;
         enable_q  <= enable_d;
      end
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_irq_sched;
   localparam int          NSRC = 4;
   localparam logic [31:0] BASE = 32'h4000_0030;
   logic       clk = 0, rst_n = 1, monin = 0, eret = 0, irq_req;
   logic [3:0] src = 0;
   logic [1:0] irq_id;
   logic [31:0] rv;
   int vectors = 0, miscompares = 0;
   irq_sched_if bus ();
   irq_sched #(.NSRC(NSRC), .BASE(BASE)) dut (
      .clk(clk), .reset(rst_n), .src(src), .monin(monin), .eret(eret),
      .bus(bus), .irq_req(irq_req), .irq_id(irq_id));
   always #5 clk = ~clk;
   // model state: state 0 idle, 1 requesting, 2 in service
   logic [3:0] m_prev = 0, m_pend = 0, m_en = 0, m_act, m_edges, m_clr;
   logic [1:0] m_svc = 0;
   int m_state = 0, m_sel;
   longint m_off;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   function automatic longint reg_off(input logic [31:0] a);
      longint o = longint'(a) - longint'(BASE);
      return (o >= 0 && o < 12 && o % 4 == 0) ? o / 4 : -1;
   endfunction
   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      case (reg_off(a))
         0: return {28'd0, m_en};
         1: return {28'd0, m_pend};
         2: return 32'(m_state * 16 + int'(m_svc));
         default: return 32'd0;
      endcase
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_prev = 0; m_pend = 0; m_en = 0; m_state = 0; m_svc = 0;
      end else begin
         m_act = m_pend & m_en;
         m_sel = -1;
         for (int i = NSRC - 1; i >= 0; i--) if (m_act[i]) m_sel = i;
         m_edges = src & ~m_prev;
         m_off = bus.wr ? reg_off(bus.addr) : -1;
         m_clr = m_off == 1 ? bus.wdata[3:0] : 4'd0;
         if (m_state == 0 && m_sel >= 0 && !monin) begin
            m_state = 1; m_svc = 2'(m_sel);
         end else if (m_state == 1 && !m_act[m_svc]) m_state = 0;
         else if (m_state == 1 && monin) begin
            m_state = 2; m_clr[m_svc] = 1'b1;
         end else if (m_state == 2 && eret) m_state = 0;
         m_pend = (m_pend & ~m_clr) | m_edges;
         if (m_off == 0) m_en = bus.wdata[3:0];
         m_prev = src;
      end
   always @(negedge clk) begin
      check("irq_req", 32'(irq_req), 32'(m_state == 1));
      check("irq_id", 32'(irq_id), 32'(m_svc));
      if (bus.rd) check("rdata", bus.rdata, exp_rdata(bus.addr));
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.wr = 1; bus.addr = a; bus.wdata = d;
      tick();
      bus.wr = 0;
   endtask
   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.rd = 1; bus.addr = a;
      #1 d = bus.rdata;
      bus.rd = 0;
   endtask
   initial begin
      bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0;
      #2 rst_n = 0;
      #1 check("rst_req", 32'(irq_req), 0);
      bus_read(BASE + 8, rv); check("rst_status", rv, 0);
      tick(2);
      rst_n = 1;
      bus_write(BASE, 32'h2);
      src[1] = 1;
      tick(2);
      check("t1_req", 32'(irq_req), 1); check("t1_id", 32'(irq_id), 1);
      monin = 1; tick(); src[1] = 0;
      bus_read(BASE + 8, rv); check("t1_status", rv, 32'h21);
      bus_read(BASE + 4, rv); check("t1_pending", rv, 0);
      check("t1_req_svc", 32'(irq_req), 0);
      monin = 0; eret = 1; tick(); eret = 0;
      bus_write(BASE, 32'hF);
      bus_read(BASE + 1, rv); check("misaligned", rv, 0);
      src = 4'b0101; tick(2);
      check("t2_req", 32'(irq_req), 1); check("t2_id0", 32'(irq_id), 0);
      monin = 1; tick(); monin = 0; eret = 1; tick(); eret = 0;
      check("t2_gap", 32'(irq_req), 0);
      tick();
      check("t2_req2", 32'(irq_req), 1); check("t2_id2", 32'(irq_id), 2);
      monin = 1; tick(); monin = 0; eret = 1; tick(); eret = 0; src = 0;
      src[3] = 1; tick(2);
      check("t3_req", 32'(irq_req), 1); check("t3_id", 32'(irq_id), 3);
      bus_write(BASE, 32'h7);
      tick();
      check("t3_drop", 32'(irq_req), 0);
      bus_read(BASE + 8, rv); check("t3_status", rv, 32'h03);
      bus_read(BASE + 4, rv); check("t3_pending", rv, 32'h8);
      bus_write(BASE + 4, 32'h8); src = 0;
      src[1] = 1; bus.wr = 1; bus.addr = BASE + 4; bus.wdata = 32'h2; tick(); bus.wr = 0;
      bus_read(BASE + 4, rv); check("t4_setwins", rv, 32'h2);
      tick();
      check("t4_req", 32'(irq_req), 1); check("t4_id", 32'(irq_id), 1);
      monin = 1; tick(); monin = 0;
      src[0] = 1; tick(); src[0] = 0;
      for (int i = 0; i < 3; i++) begin
         tick(); check("t5_hold", 32'(irq_req), 0);
      end
      eret = 1; tick(); eret = 0; tick();
      check("t5_req", 32'(irq_req), 1); check("t5_id", 32'(irq_id), 0);
      monin = 1; tick(); monin = 0; eret = 1; tick(); eret = 0; src = 0;
      src[2] = 1; tick(2);
      check("t6_req", 32'(irq_req), 1);
      #1 rst_n = 0;
      #1 check("t6_req_rst", 32'(irq_req), 0);
      bus_read(BASE, rv); check("t6_enable", rv, 0);
      bus_read(BASE + 4, rv); check("t6_pending", rv, 0);
      bus_read(BASE + 8, rv); check("t6_status", rv, 0);
      bus_read(BASE + 12, rv); check("t6_offc", rv, 0);
      tick(); rst_n = 1; src = 0;
      repeat (4000) begin
         for (int b = 0; b < NSRC; b++) if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
         monin = $urandom_range(0, 2) == 0;
         eret = $urandom_range(0, 5) == 0;
         bus.rd = 1'($urandom_range(0, 1));
         bus.wr = $urandom_range(0, 9) == 0;
         bus.wdata = $urandom;
         case ($urandom_range(0, 5))
            0: bus.addr = BASE;
            1: bus.addr = BASE + 4;
            2: bus.addr = BASE + 8;
            3: bus.addr = BASE + 12;
            4: bus.addr = BASE + 32'($urandom_range(1, 11));
            default: bus.addr = $urandom;
         endcase
         rst_n = $urandom_range(0, 799) != 0;
         tick();
         rst_n = 1;
      end
      bus.rd = 0; bus.wr = 0;
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
